// File: rtl/demux8_deser.sv
// Serial-to-parallel receiver: bits land LSB first in an assembly register,
// completed bytes move into a one-entry valid/ready output buffer.
module demux8_deser (
  input  logic       clk,
  input  logic       rst,
  input  logic       i,
  input  logic       i_valid,
  input  logic       sync,
  output logic [2:0] s,
  output logic [7:0] y,
  output logic       y_valid,
  input  logic       y_ready,
  output logic       ovf,
  input  logic       ovf_clr
);

  // Output handshake: a byte transfers on every edge where y_valid && y_ready;
  // y only changes when a completed byte is loaded, never on consumption.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

  buf_state_e state_q, state_d;
  logic [2:0] s_q, s_d;
  logic [6:0] sh_q, sh_d;
  logic [7:0] y_q, y_d;
  logic       ovf_q, ovf_d;

  logic complete;
  logic load;
  logic drop;

  assign complete = i_valid && !sync && (s_q == 3'd7);
  assign load     = complete && ((state_q == EMPTY) || y_ready);
  assign drop     = complete && (state_q == FULL) && !y_ready;

  always_comb begin
    s_d     = s_q;
    sh_d    = sh_q;
    y_d     = y_q;
    state_d = state_q;
    ovf_d   = ovf_q;

    // sync restarts the frame; a bit arriving with it becomes bit 0
    if (sync) begin
      sh_d = '0;
      s_d  = 3'd0;
      if (i_valid) begin
        sh_d[0] = i;
        s_d     = 3'd1;
      end
    end else if (i_valid) begin
      if (s_q != 3'd7) sh_d[s_q] = i;
      s_d = s_q + 3'd1;
    end

    if (load) y_d = {i, sh_q};

    case (state_q)
      EMPTY:   if (complete) state_d = FULL;
      FULL:    if (!complete && y_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    // a drop on the same edge as a clear leaves ovf set
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      s_q     <= 3'd0;
      sh_q    <= 7'd0;
      y_q     <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      sh_q    <= sh_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
    end
  end

  assign s       = s_q;
  assign y       = y_q;
  assign y_valid = (state_q == FULL);
  assign ovf     = ovf_q;

endmodule

// File: doc/demux8_deser.md
# demux8_deser

Serial-to-parallel demultiplexer: the receiving end of an 8-to-1 bit-select path. Each accepted serial bit is steered to bit position `s` of an 8-bit assembly register. `s` runs 0..7, LSB first, matching select order 0..7 on the transmit side. Completed bytes go into a one-entry output buffer with a valid/ready handshake. Frame alignment is by an explicit `sync` strobe, and lost bytes are flagged by a sticky overflow.

## Interface
Parameters: none; width fixed at 8 bits, index width 3.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i` in 1: serial data bit.
- `i_valid` in 1: `i` is accepted on this edge.
- `sync` in 1: frame-align strobe; discards the partial byte.
- `s` out 3: index where the next accepted bit lands (internal counter).
- `y` out 8: assembled byte; `y[k]` is the bit accepted at `s==k`.
- `y_valid` out 1: `y` holds an unconsumed byte.
- `y_ready` in 1: consumer takes `y` when `y_valid && y_ready`.
- `ovf` out 1: sticky; a completed byte was dropped.
- `ovf_clr` in 1: synchronous clear of `ovf`.

## Operation
- Assembly register `sh[6:0]` and counter `s`:
  - On an edge with `i_valid=1`: `sh[s] <= i`, then `s <= s+1`, wrapping 7 to 0.
  - With `i_valid=0`, nothing changes in the assembly path; gaps of any length are allowed.
- `sync=1` forces alignment and discards all partial bits:
  - With `i_valid=0`: `s <= 0`.
  - With `i_valid=1` on the same edge: the bit is taken as bit 0 of a new frame (`sh[0] <= i`, `s <= 1`).
  - `sync` has no effect on `y`, `y_valid` or `ovf`.
- Completion is an edge with `i_valid=1`, `s==7`, `sync=0`. The completed byte is `{i, sh[6:0]}`.
- Output buffer has two states:
  - EMPTY (`y_valid=0`) and FULL (`y_valid=1`).
  - EMPTY → FULL on completion.
  - FULL → EMPTY on `y_ready=1` with no completion.
  - FULL stays FULL on completion with `y_ready=1`: the new byte replaces `y` (simultaneous drain and load, no loss).
  - FULL with `y_ready=0` on completion: the byte is dropped, `y` is unchanged, `ovf <= 1`.
- `ovf` priority:
  - `ovf_clr` clears `ovf`.
  - If `ovf_clr` and a drop occur on the same edge, the set wins and `ovf=1`.
- `y` changes only on a load; it holds its value after being consumed.
- `y_ready` while EMPTY has no effect.

## Timing
- Reset (async assert, any time) gives: `s=0`, `sh=0`, `y=8'h00`, `y_valid=0`, `ovf=0`.
  - Reset mid-frame discards the partial byte and any pending output.
  - The first bit accepted after deassertion is bit 0.
- Latency:
  - `y` and `y_valid` update on the same edge that accepts bit 7; they are visible in the following cycle.
  - Minimum frame time is 8 cycles; sustained throughput is 1 byte per 8 cycles with `y_ready` held high.
- Handshake:
  - `y` is stable while `y_valid=1 && y_ready=0`, except that it never changes without a load.
  - A transfer occurs on each edge with `y_valid && y_ready`.
- `s` is registered and reflects accepted bits only. It is valid from the cycle after reset.
- `ovf` rises the cycle after the dropping edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset values:** assert `rst` asynchronously between edges → `s=0`, `y=00`, `y_valid=0`, `ovf=0` immediately; the held values remain after release.
- **Basic byte:** bits 1,0,1,0,0,1,0,1 on 8 consecutive edges, `y_ready=1`.
  - `y=8'hA5` and `y_valid=1` for exactly 1 cycle; `s` returns to 0.
- **Gapped input and sync:** send 3 bits of 8'h3C, then `sync` with `i_valid=0`, then 8'h0F with 2-cycle gaps between bits.
  - Only `y=8'h0F` is produced; `s` sequence is 0..3, 0, then 1..7, 0.
- **Backpressure and overflow:** `y_ready=0`, send 8'h12 then 8'h34.
  - `y=8'h12` held, `y_valid=1`, `ovf=1` after the 16th bit.
  - Then pulse `y_ready` → `y_valid=0`, `y` stays 12.
  - Pulse `ovf_clr` → `ovf=0`.
- **Simultaneous drain and load:** `y` full with 8'hAA; raise `y_ready` exactly on the edge that completes 8'h55.
  - `y=8'h55`, `y_valid` stays 1, `ovf=0`.
- **Sync with data, and reset mid-frame:**
  - After 5 bits, assert `sync` with `i_valid=1, i=1`, then 7 more bits of 0 → `y=8'h01`.
  - Separately, assert `rst` after bit 4 → no output; the next full byte decodes correctly.
